// File: rtl/codec_rx.sv
`timescale 1ns/1ps
// codec_rx: I2S master receiver. Generates sclk/lrclk and deserializes 16-bit left/right
// samples. Define CODEC_RX_DC_REMOVE_EN to add a per-channel DC-removal high-pass at load.
module codec_rx #(
   parameter int unsigned SCLK_HALF = 8,
   parameter int unsigned VALID_LEN = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sdin,
   output logic        sclk,
   output logic        lrclk,
   output logic        VALID,
   output logic [15:0] left_out,
   output logic [15:0] right_out
);

   localparam int unsigned VW = $clog2(VALID_LEN + 1);

   logic [7:0]    div_cnt;
   logic [5:0]    bit_cnt;
   logic          div_wrap;
   logic          sclk_rise;
   logic          cap_en;
   logic          load_pend;
   logic [15:0]   left_sr;
   logic [15:0]   right_sr;
   logic [15:0]   left_next;
   logic [15:0]   right_next;
   logic [VW-1:0] valid_cnt;

   always_comb begin
      div_wrap  = (div_cnt == 8'(SCLK_HALF - 1));
      sclk_rise = div_wrap & ~sclk;
      // Slot position 0 is the I2S delay bit; 17..31 carry nothing we use.
      cap_en    = sclk_rise && (bit_cnt[4:0] >= 5'd1) && (bit_cnt[4:0] <= 5'd16);
   end

   assign lrclk = bit_cnt[5];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
         bit_cnt <= '0;
      end else if (div_wrap) begin
         div_cnt <= '0;
         sclk    <= ~sclk;
         if (sclk) bit_cnt <= bit_cnt + 6'd1;
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left_sr   <= '0;
         right_sr  <= '0;
         load_pend <= 1'b0;
      end else begin
         load_pend <= sclk_rise && (bit_cnt == 6'd48);
         if (cap_en) begin
            if (bit_cnt[5]) right_sr <= {right_sr[14:0], sdin};
            else            left_sr  <= {left_sr[14:0], sdin};
         end
      end
   end

`ifdef CODEC_RX_DC_REMOVE_EN
   logic [23:0] avg_l;
   logic [23:0] avg_r;

   // sat16(x - avg[23:8])
   function automatic logic [15:0] dc_out(input logic [15:0] x, input logic [23:0] avg);
      logic [16:0] d;
      d = {x[15], x} - {avg[23], avg[23:8]};
      if (d[16] != d[15]) return d[16] ? 16'h8000 : 16'h7FFF;
      return d[15:0];
   endfunction

   // avg + ((x << 8) - avg) >>> 8, in 16.8 fixed point
   function automatic logic [23:0] dc_avg(input logic [15:0] x, input logic [23:0] avg);
      logic signed [24:0] diff;
      diff = $signed({x[15], x, 8'h00}) - $signed({avg[23], avg});
      return 24'($signed({avg[23], avg}) + (diff >>> 8));
   endfunction

   always_comb begin
      left_next  = dc_out(left_sr, avg_l);
      right_next = dc_out(right_sr, avg_r);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         avg_l <= '0;
         avg_r <= '0;
      end else if (load_pend) begin
         avg_l <= dc_avg(left_sr, avg_l);
         avg_r <= dc_avg(right_sr, avg_r);
      end
   end
`else
   always_comb begin
      left_next  = left_sr;
      right_next = right_sr;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left_out  <= '0;
         right_out <= '0;
         VALID     <= 1'b0;
         valid_cnt <= '0;
      end else if (load_pend) begin
         left_out  <= left_next;
         right_out <= right_next;
         VALID     <= 1'b1;
         valid_cnt <= VW'(VALID_LEN - 1);
      end else if (VALID) begin
         if (valid_cnt == '0) VALID <= 1'b0;
         else                 valid_cnt <= valid_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_codec_rx.sv
`timescale 1ns/1ps
// tb_codec_rx: directed bench with a behavioural I2S codec model driving two receivers
// (SCLK_HALF = 8 and SCLK_HALF = 2).
module tb_codec_rx;

   localparam int unsigned H1 = 8;
   localparam int unsigned V1 = 4;
   localparam int unsigned H2 = 2;
   localparam int unsigned V2 = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sdin1, sdin2;
   logic        sclk1, sclk2, lrclk1, lrclk2, valid1, valid2;
   logic [15:0] l1, r1, l2, r2;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [15:0] frame_l [16];
   logic [15:0] frame_r [16];
   logic        fill = 1'b0;
   logic [5:0]  fcnt1, fcnt2;
   logic [3:0]  fidx1, fidx2;

   codec_rx #(.SCLK_HALF(H1), .VALID_LEN(V1)) dut (
      .clk(clk), .rst_n(rst_n), .sdin(sdin1), .sclk(sclk1), .lrclk(lrclk1),
      .VALID(valid1), .left_out(l1), .right_out(r1)
   );

   codec_rx #(.SCLK_HALF(H2), .VALID_LEN(V2)) dut2 (
      .clk(clk), .rst_n(rst_n), .sdin(sdin2), .sclk(sclk2), .lrclk(lrclk2),
      .VALID(valid2), .left_out(l2), .right_out(r2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Codec model: tracks its own bit position off sclk falling edges, MSB at p = 1.
   function automatic logic sd_bit(input logic [5:0] fc, input logic [15:0] wl,
                                   input logic [15:0] wr, input logic f);
      int p;
      logic [15:0] w;
      p = int'(fc[4:0]);
      w = fc[5] ? wr : wl;
      if (p >= 1 && p <= 16) return w[16-p];
      return f;
   endfunction

   assign sdin1 = sd_bit(fcnt1, frame_l[fidx1], frame_r[fidx1], fill);
   assign sdin2 = sd_bit(fcnt2, frame_l[fidx2], frame_r[fidx2], fill);

   always @(negedge sclk1 or negedge rst_n) begin
      if (!rst_n) begin
         fcnt1 <= '0;
         fidx1 <= '0;
      end else begin
         if (fcnt1 == 6'd63) fidx1 <= fidx1 + 4'd1;
         fcnt1 <= fcnt1 + 6'd1;
      end
   end

   always @(negedge sclk2 or negedge rst_n) begin
      if (!rst_n) begin
         fcnt2 <= '0;
         fidx2 <= '0;
      end else begin
         if (fcnt2 == 6'd63) fidx2 <= fidx2 + 4'd1;
         fcnt2 <= fcnt2 + 6'd1;
      end
   end

   task automatic hold_reset();
      @(negedge clk);
      rst_n = 1'b0;
   endtask

   task automatic set_frames(input logic [15:0] wl, input logic [15:0] wr);
      for (int i = 0; i < 16; i++) begin
         frame_l[i] = wl;
         frame_r[i] = wr;
      end
   endtask

   task automatic wait_rise(input int w, input int bound, output logic found, output int at);
      logic pv, v;
      int n;
      found = 1'b0;
      at = 0;
      n = 0;
      pv = (w == 1) ? valid2 : valid1;
      while (!found && n < bound) begin
         @(posedge clk);
         #1;
         n++;
         v = (w == 1) ? valid2 : valid1;
         if (v && !pv) begin
            found = 1'b1;
            at = cyc;
         end
         pv = v;
      end
   endtask

   task automatic test_single_frame();
      logic found, stable;
      int at, t0, len;
      hold_reset();
      fill = 1'b0;
      set_frames(16'h0000, 16'h0000);
      frame_l[0] = 16'hA5C3;
      frame_r[0] = 16'h1234;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      t0 = cyc;
      wait_rise(0, 3000, found, at);
      n_cmp++;
      if (found !== 1'b1) begin
         n_bad++;
         $display("FAIL single_valid_seen: got %b want 1", found);
      end
      n_cmp++;
      if (at - t0 != int'(97 * H1 + 1)) begin
         n_bad++;
         $display("FAIL single_latency: got %0d want %0d", at - t0, 97 * H1 + 1);
      end
      n_cmp++;
      if (l1 !== 16'hA5C3) begin
         n_bad++;
         $display("FAIL single_left: got %h want a5c3", l1);
      end
      n_cmp++;
      if (r1 !== 16'h1234) begin
         n_bad++;
         $display("FAIL single_right: got %h want 1234", r1);
      end
      len = 1;
      stable = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (!valid1) break;
         len++;
         if (l1 !== 16'hA5C3 || r1 !== 16'h1234) stable = 1'b0;
      end
      n_cmp++;
      if (len != int'(V1)) begin
         n_bad++;
         $display("FAIL single_valid_len: got %0d want %0d", len, V1);
      end
      n_cmp++;
      if (stable !== 1'b1) begin
         n_bad++;
         $display("FAIL single_stable_in_valid: got %b want 1", stable);
      end
      repeat (30) @(posedge clk);
      #1;
      n_cmp++;
      if (l1 !== 16'hA5C3 || r1 !== 16'h1234) begin
         n_bad++;
         $display("FAIL single_hold_after: got %h/%h want a5c3/1234", l1, r1);
      end
   endtask

   task automatic test_reset();
      int t1, t2;
      repeat (100) @(posedge clk);
      hold_reset();
      #1;
      n_cmp++;
      if ({sclk1, lrclk1, valid1} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_ctl1: got %b want 000", {sclk1, lrclk1, valid1});
      end
      n_cmp++;
      if (l1 !== 16'h0 || r1 !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_out1: got %h/%h want 0000/0000", l1, r1);
      end
      n_cmp++;
      if ({sclk2, lrclk2, valid2} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_ctl2: got %b want 000", {sclk2, lrclk2, valid2});
      end
      n_cmp++;
      if (l2 !== 16'h0 || r2 !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_out2: got %h/%h want 0000/0000", l2, r2);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      t1 = 0;
      t2 = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (sclk1 && t1 == 0) t1 = k;
         if (sclk2 && t2 == 0) t2 = k;
      end
      n_cmp++;
      if (t1 != int'(H1)) begin
         n_bad++;
         $display("FAIL reset_first_sclk1: got %0d want %0d", t1, H1);
      end
      n_cmp++;
      if (t2 != int'(H2)) begin
         n_bad++;
         $display("FAIL reset_first_sclk2: got %0d want %0d", t2, H2);
      end
   endtask

   task automatic test_slot_edges();
      logic found;
      int at;
      hold_reset();
      fill = 1'b1;
      set_frames(16'h0001, 16'h0001);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_rise(0, 3000, found, at);
      n_cmp++;
      if (found !== 1'b1) begin
         n_bad++;
         $display("FAIL slot_valid_seen: got %b want 1", found);
      end
      n_cmp++;
      if (l1 !== 16'h0001 || r1 !== 16'h0001) begin
         n_bad++;
         $display("FAIL slot_out1: got %h/%h want 0001/0001", l1, r1);
      end
      n_cmp++;
      if (l2 !== 16'h0001 || r2 !== 16'h0001) begin
         n_bad++;
         $display("FAIL slot_out2: got %h/%h want 0001/0001", l2, r2);
      end
      fill = 1'b0;
   endtask

   task automatic rate_monitor(input int w, input int h);
      logic found;
      int at, last;
      logic [15:0] lo, ro, el, er;
      last = 0;
      for (int k = 0; k < 10; k++) begin
         wait_rise(w, 256 * h + 50, found, at);
         n_cmp++;
         if (found !== 1'b1) begin
            n_bad++;
            $display("FAIL rate%0d_valid_seen frame %0d: got %b want 1", w, k, found);
            return;
         end
         lo = (w == 1) ? l2 : l1;
         ro = (w == 1) ? r2 : r1;
         el = 16'(k + 1);
         er = 16'(-(k + 1));
         n_cmp++;
         if (lo !== el || ro !== er) begin
            n_bad++;
            $display("FAIL rate%0d_data frame %0d: got %h/%h want %h/%h", w, k, lo, ro, el, er);
         end
         if (k > 0) begin
            n_cmp++;
            if (at - last != 128 * h) begin
               n_bad++;
               $display("FAIL rate%0d_period frame %0d: got %0d want %0d", w, k, at - last,
                        128 * h);
            end
         end
         last = at;
      end
   endtask

   task automatic test_frame_rate();
      hold_reset();
      fill = 1'b0;
      for (int k = 0; k < 16; k++) begin
         frame_l[k] = 16'(k + 1);
         frame_r[k] = 16'(-(k + 1));
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      fork
         rate_monitor(0, int'(H1));
         rate_monitor(1, int'(H2));
      join
   endtask

   task automatic test_reset_mid_capture();
      logic found, seen;
      int at, t0, n;
      hold_reset();
      fill = 1'b0;
      set_frames(16'h1357, 16'h9BDF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      n = 0;
      while (fcnt1 != 6'd40 && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
         if (valid1) seen = 1'b1;
      end
      n_cmp++;
      if (fcnt1 !== 6'd40) begin
         n_bad++;
         $display("FAIL midcap_reach_bit40: got %0d want 40", fcnt1);
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL midcap_no_early_valid: got %b want 0", seen);
      end
      hold_reset();
      set_frames(16'h4C2E, 16'hF00D);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      t0 = cyc;
      #1;
      n_cmp++;
      if (l1 !== 16'h0 || r1 !== 16'h0 || valid1 !== 1'b0) begin
         n_bad++;
         $display("FAIL midcap_cleared: got %h/%h v=%b want 0000/0000 v=0", l1, r1, valid1);
      end
      wait_rise(0, 3000, found, at);
      n_cmp++;
      if (found !== 1'b1 || at - t0 != int'(97 * H1 + 1)) begin
         n_bad++;
         $display("FAIL midcap_latency: got found=%b lat=%0d want 1/%0d", found, at - t0,
                  97 * H1 + 1);
      end
      n_cmp++;
      if (l1 !== 16'h4C2E || r1 !== 16'hF00D) begin
         n_bad++;
         $display("FAIL midcap_data: got %h/%h want 4c2e/f00d", l1, r1);
      end
   endtask

`ifdef CODEC_RX_DC_REMOVE_EN
   task automatic test_dc_remove();
      logic found;
      int at;
      logic [15:0] e;
      hold_reset();
      fill = 1'b0;
      set_frames(16'h1000, 16'h1000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_rise(0, 3000, found, at);
         e = (k == 0) ? 16'h1000 : (k == 1) ? 16'h0FF0 : 16'h0FE1;
         n_cmp++;
         if (found !== 1'b1 || l1 !== e || r1 !== e) begin
            n_bad++;
            $display("FAIL dc_frame%0d: got %h/%h found=%b want %h/%h", k, l1, r1, found, e, e);
         end
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      set_frames(16'h0000, 16'h0000);
      repeat (3) @(negedge clk);
      test_single_frame();
      test_reset();
      test_reset_mid_capture();
`ifdef CODEC_RX_DC_REMOVE_EN
      test_dc_remove();
`else
      test_slot_edges();
      test_frame_rate();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
